// File: rtl/step_cmd_gen.sv
// ============================================================================
// Module   : step_cmd_gen
// Brief    : Step/direction command generator: N step pulses spaced P cycles.
//            Optional acceleration ramp compiled in with STEP_CMD_RAMP_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module step_cmd_gen #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         dir_in,
  input  logic [W-1:0] steps,
  input  logic [W-1:0] period,
  input  logic         abort,
  output logic         step,
  output logic         dir,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] steps_left
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  localparam logic [W-1:0] c_one   = W'(1);
  localparam logic [W:0]   c_one_x = (W+1)'(1);

  state_t       r_state;
  logic [W-1:0] r_p;
  logic [W:0]   r_cnt;
  logic [W-1:0] r_left;
  logic         r_step;
  logic         r_dir;
  logic         r_busy;
  logic         r_done;

  logic [W-1:0] w_p_eff;
  logic [W-1:0] w_left_dec;
  logic [W:0]   w_iv_first;
  logic [W:0]   w_iv_next;

  assign w_p_eff    = (period == '0) ? c_one : period;
  assign w_left_dec = r_left - c_one;

`ifdef STEP_CMD_RAMP_EN
  // Index (k-1) of the pulse just issued; interval widens early pulses.
  logic [W-1:0] r_km1;

  function automatic logic [W:0] f_interval(input logic [W-1:0] p,
                                            input logic [W-1:0] km1);
    logic [W:0] two_p;
    logic [W:0] pw;
    logic [W:0] sub;
    two_p = {p, 1'b0};
    pw    = {1'b0, p};
    sub   = (two_p > {1'b0, km1}) ? (two_p - {1'b0, km1}) : '0;
    return (sub > pw) ? sub : pw;
  endfunction

  assign w_iv_first = f_interval(w_p_eff, '0);
  assign w_iv_next  = f_interval(r_p, r_km1 + c_one);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_km1 <= '0;
    end else if (r_state == S_IDLE) begin
      r_km1 <= '0;
    end else if (r_state == S_RUN && r_step) begin
      r_km1 <= r_km1 + c_one;
    end
  end
`else
  assign w_iv_first = {1'b0, w_p_eff};
  assign w_iv_next  = {1'b0, r_p};
`endif

  // r_cnt holds cycles remaining until the next step cycle; r_step is
  // pre-computed one edge ahead so the pulse itself is a register output.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_p     <= '0;
      r_cnt   <= '0;
      r_left  <= '0;
      r_step  <= 1'b0;
      r_dir   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_step <= 1'b0;
          r_done <= 1'b0;
          if (start) begin
            r_dir  <= dir_in;
            r_p    <= w_p_eff;
            r_left <= steps;
            if (steps == '0) begin
              r_state <= S_FIN;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
              r_cnt   <= w_iv_first - c_one_x;
              r_step  <= (w_iv_first == c_one_x);
            end
          end
        end
        S_RUN: begin
          if (r_step) begin
            r_left <= w_left_dec;
          end
          if (abort) begin
            r_state <= S_IDLE;
            r_step  <= 1'b0;
            r_busy  <= 1'b0;
          end else if (r_step) begin
            if (w_left_dec == '0) begin
              r_state <= S_FIN;
              r_step  <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_cnt  <= w_iv_next - c_one_x;
              r_step <= (w_iv_next == c_one_x);
            end
          end else begin
            r_cnt  <= r_cnt - c_one_x;
            r_step <= (r_cnt == c_one_x);
          end
        end
        S_FIN: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_step  <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign step       = r_step;
  assign dir        = r_dir;
  assign busy       = r_busy;
  assign done       = r_done;
  assign steps_left = r_left;

endmodule

`default_nettype wire

// File: tb/tb_step_cmd_gen.sv
// ============================================================================
// Module   : tb_step_cmd_gen
// Brief    : Scoreboard bench for step_cmd_gen; per-cycle expectations queued
//            by the stimulus process and checked by an independent monitor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_step_cmd_gen;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic         start;
  logic         dir_in;
  logic [W-1:0] steps;
  logic [W-1:0] period;
  logic         abort;
  logic         step;
  logic         dir;
  logic         busy;
  logic         done;
  logic [W-1:0] steps_left;

  typedef struct packed {
    logic         step;
    logic         dir;
    logic         busy;
    logic         done;
    logic [W-1:0] left;
  } exp_t;

  exp_t q[$];
  int   checks;
  int   errors;
  int   cyc;
  logic prev_dir;
  int   prev_left;

  step_cmd_gen #(.W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dir_in     (dir_in),
    .steps      (steps),
    .period     (period),
    .abort      (abort),
    .step       (step),
    .dir        (dir),
    .busy       (busy),
    .done       (done),
    .steps_left (steps_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Monitor: compares every presented cycle against the queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("step",       int'(step),       int'(e.step));
      chk("dir",        int'(dir),        int'(e.dir));
      chk("busy",       int'(busy),       int'(e.busy));
      chk("done",       int'(done),       int'(e.done));
      chk("steps_left", int'(steps_left), int'(e.left));
    end
  end

  // Relative cycle r=0 is T0 (start high). s0..s3: hand-computed step cycles.
  task automatic run_case(input int n, input int p, input int d,
                          input int ab_r, input int st2_r, input int rst_r,
                          input int dn_r, input int bl, input int bh, input int len,
                          input int s0, input int s1, input int s2, input int s3,
                          input int ns);
    int   sl[4];
    int   cnt;
    exp_t e;
    sl[0] = s0; sl[1] = s1; sl[2] = s2; sl[3] = s3;
    for (int r = 0; r <= len; r++) begin
      @(posedge clk);
      #1;
      start  = (r == 0) || (r == st2_r);
      dir_in = (r == 0) ? d[0] : ~d[0];
      steps  = (r == 0) ? W'(n) : W'(9);
      period = (r == 0) ? W'(p) : W'(1);
      abort  = (r == ab_r);
      rst    = (r == rst_r);
      if (r == 0) begin
        e = '{step: 1'b0, dir: prev_dir, busy: 1'b0, done: 1'b0, left: W'(prev_left)};
      end else if (rst_r >= 0 && r > rst_r) begin
        e = '0;
      end else begin
        cnt    = 0;
        e      = '0;
        for (int i = 0; i < ns; i++) begin
          if (sl[i] < r)  cnt++;
          if (sl[i] == r) e.step = 1'b1;
        end
        e.dir  = d[0];
        e.busy = (r >= bl) && (r <= bh);
        e.done = (r == dn_r);
        e.left = W'(n - cnt);
      end
      q.push_back(e);
    end
    start = 1'b0;
    abort = 1'b0;
    rst   = 1'b0;
    if (rst_r >= 0) begin
      prev_dir  = 1'b0;
      prev_left = 0;
    end else begin
      prev_dir  = d[0];
      prev_left = n - ns;
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    prev_dir  = 1'b0;
    prev_left = 0;
    rst       = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    dir_in    = 1'b0;
    steps     = '0;
    period    = '0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (i == 3) rst = 1'b0;
      q.push_back('0);
    end
    repeat (6) @(posedge clk);

`ifdef STEP_CMD_RAMP_EN
    // N=4,P=3: intervals 6,5,4,3
    run_case(4, 3, 1, -1, -1, -1, 19, 1, 18, 22, 6, 11, 15, 18, 4);
    run_case(0, 5, 0, -1, -1, -1, 1, 1, 0, 4, 0, 0, 0, 0, 0);
`else
    // N=3,P=4,dir=1
    run_case(3, 4, 1, -1, -1, -1, 13, 1, 12, 16, 4, 8, 12, 0, 3);
    // N=0: done only
    run_case(0, 5, 0, -1, -1, -1, 1, 1, 0, 4, 0, 0, 0, 0, 0);
    // N=5,P=2, abort on 2nd step
    run_case(5, 2, 1, 4, -1, -1, -1, 1, 4, 10, 2, 4, 0, 0, 2);
    // N=2,P=3, second start at r=2 ignored
    run_case(2, 3, 0, -1, 2, -1, 7, 1, 6, 10, 3, 6, 0, 0, 2);
    // N=4,P=3, reset at r=5
    run_case(4, 3, 1, -1, -1, 5, -1, 1, 5, 10, 3, 0, 0, 0, 1);
    // P=0 behaves as P=1
    run_case(2, 0, 1, -1, -1, -1, 3, 1, 2, 6, 1, 2, 0, 0, 2);
    // abort in IDLE alongside start is ignored
    run_case(1, 2, 0, 0, -1, -1, 3, 1, 2, 6, 2, 0, 0, 0, 1);
`endif

    repeat (3) @(posedge clk);
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
